// File: rtl/mr_sched.sv
// mr_sched: two-requester round-robin scheduler for a shared Kyber/Dilithium modular-reduction
// unit, with mode draining, credit-based flow control and an in-order FWFT result FIFO.
module mr_sched #(
    parameter int TAG_W      = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [1:0]       req_mode,
    input  logic [45:0]      req_d0,
    input  logic [45:0]      req_d1,
    input  logic [TAG_W-1:0] req_tag0,
    input  logic [TAG_W-1:0] req_tag1,
    output logic [1:0]       req_ready,
    output logic             mr_mode,
    output logic [45:0]      mr_d,
    input  logic [23:0]      mr_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [TAG_W-1:0] res_tag,
    output logic [23:0]      res_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_nx;

    logic                        ptr;
    logic [2:0]                  sh_v;
    logic [2:0]                  sh_id;
    logic [2:0]                  sh_mode;
    logic [2:0][TAG_W-1:0]       sh_tag;

    logic [CW-1:0]               fifo_cnt;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic [FIFO_DEPTH-1:0]       mem_id;
    logic [TAG_W-1:0]            mem_tag  [FIFO_DEPTH];
    logic [23:0]                 mem_data [FIFO_DEPTH];

    logic                        cand;
    logic                        cand_mode;
    logic                        any_valid;
    logic                        grant;
    logic                        mode_flip;
    logic [CW:0]                 used;
    logic                        credit;
    logic                        push;
    logic                        pop;
    logic                        fifo_empty;
    logic                        fifo_full;
    logic [23:0]                 push_data;

    assign any_valid = |req_valid;
    assign cand      = req_valid[ptr] ? ptr : ~ptr;
    assign cand_mode = req_mode[cand];

    // Credit counts everything that will land in the FIFO; a pop in this same cycle is not credited.
    assign used   = {1'b0, fifo_cnt} + (CW+1)'(sh_v[0]) + (CW+1)'(sh_v[1]) + (CW+1)'(sh_v[2]);
    assign credit = used < (CW+1)'(FIFO_DEPTH);

    always_comb begin
        state_nx  = state;
        grant     = 1'b0;
        mode_flip = 1'b0;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (any_valid) state_nx = ISSUE;
            end
            ISSUE: begin
                if (!any_valid) begin
                    state_nx = IDLE;
                end else if (cand_mode != mr_mode) begin
                    state_nx = DRAIN;
                end else if (credit) begin
                    grant           = 1'b1;
                    req_ready[cand] = 1'b1;
                end
            end
            DRAIN: begin
                // Stage 2 leaves at this edge, so the new mode first appears with an empty pipe.
                if (sh_v[1:0] == '0) begin
                    mode_flip = 1'b1;
                    state_nx  = ISSUE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            mr_mode <= 1'b0;
            mr_d    <= '0;
            sh_v    <= '0;
            sh_id   <= '0;
            sh_mode <= '0;
            sh_tag  <= '0;
        end else begin
            state   <= state_nx;
            mr_d    <= grant ? (cand ? req_d1 : req_d0) : '0;
            sh_v    <= {sh_v[1:0], grant};
            sh_id   <= {sh_id[1:0], cand};
            sh_mode <= {sh_mode[1:0], mr_mode};
            sh_tag  <= {sh_tag[1], sh_tag[0], (cand ? req_tag1 : req_tag0)};
            if (grant) ptr <= ~cand;
            if (mode_flip) mr_mode <= ~mr_mode;
        end
    end

    assign push       = sh_v[2];
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
    assign pop        = res_valid & res_ready;
    assign push_data  = sh_mode[2] ? mr_result : {11'd0, mr_result[12:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_id[wr_ptr]   <= sh_id[2];
            mem_tag[wr_ptr]  <= sh_tag[2];
            mem_data[wr_ptr] <= push_data;
        end
    end

    // Outputs are masked while empty so the unreset storage never shows through.
    assign res_valid = ~fifo_empty;
    assign res_id    = fifo_empty ? 1'b0 : mem_id[rd_ptr];
    assign res_tag   = fifo_empty ? '0 : mem_tag[rd_ptr];
    assign res_data  = fifo_empty ? '0 : mem_data[rd_ptr];

    no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_mr_sched.sv
// Self-checking bench for mr_sched: reduction-unit model, accept/result scoreboard and
// spec-level occupancy/credit model, with directed and randomized scenarios.
`timescale 1ns/1ps
module tb_mr_sched;
    localparam int TAG_W = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_mode = '0;
    logic [45:0]      req_d0 = '0;
    logic [45:0]      req_d1 = '0;
    logic [TAG_W-1:0] req_tag0 = '0;
    logic [TAG_W-1:0] req_tag1 = '0;
    logic [1:0]       req_ready;
    logic             mr_mode;
    logic [45:0]      mr_d;
    logic [23:0]      mr_result;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic             res_id;
    logic [TAG_W-1:0] res_tag;
    logic [23:0]      res_data;

    always #5 clk = ~clk;

    mr_sched #(.TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_mode(req_mode),
        .req_d0(req_d0), .req_d1(req_d1), .req_tag0(req_tag0), .req_tag1(req_tag1),
        .req_ready(req_ready), .mr_mode(mr_mode), .mr_d(mr_d), .mr_result(mr_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_tag(res_tag), .res_data(res_data)
    );

    function automatic logic [23:0] golden(input logic m, input logic [45:0] d);
        longint unsigned dd, q;
        dd = 64'(d);
        q  = m ? 64'd8380417 : 64'd3329;
        return 24'(dd % q);
    endfunction

    // Reduction unit: 2-cycle latency, Kyber results carry junk in bits [23:13].
    function automatic logic [23:0] unit_out(input logic m, input logic [45:0] d);
        logic [23:0] r;
        r = golden(m, d);
        if (!m) r[23:13] = 11'h400 | {1'b0, d[9:0]};
        return r;
    endfunction

    logic [23:0] p1;
    always @(posedge clk) begin
        p1        <= unit_out(mr_mode, mr_d);
        mr_result <= p1;
    end

    function automatic logic [45:0] rand46();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[45:0];
    endfunction

    typedef struct {
        int               cyc;
        logic             id;
        logic [TAG_W-1:0] tag;
        logic [23:0]      data;
    } ev_t;

    ev_t  acc_q[$];
    ev_t  pop_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   mode_bad = 0, multi_bad = 0, credit_bad = 0, occ_bad = 0, mode_changes = 0;
    int   occ, m_infl;
    logic [3:0] acc_hist;
    logic       popped_prev, prev_mode;
    logic [1:0] m_acc;
    ev_t        m_e;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: logs accepts with golden data and pops; models FIFO occupancy from accept times.
    always @(negedge clk) begin
        if (rst) begin
            acc_q.delete();
            pop_q.delete();
            occ = 0;
            acc_hist = '0;
            popped_prev = 1'b0;
            prev_mode = 1'b0;
        end else begin
            m_acc  = req_valid & req_ready;
            occ    = occ + int'(acc_hist[3]) - int'(popped_prev);
            m_infl = int'(acc_hist[0]) + int'(acc_hist[1]) + int'(acc_hist[2]);
            if (res_valid !== (occ != 0)) occ_bad++;
            if (m_acc == 2'b11) multi_bad++;
            if (m_acc != 2'b00) begin
                if (m_infl + occ >= DEPTH) credit_bad++;
                m_e.cyc  = cyc;
                m_e.id   = m_acc[1];
                m_e.tag  = m_acc[1] ? req_tag1 : req_tag0;
                m_e.data = golden(req_mode[m_acc[1]], m_acc[1] ? req_d1 : req_d0);
                acc_q.push_back(m_e);
            end
            if (mr_mode !== prev_mode) begin
                mode_changes++;
                if (m_infl != 0) mode_bad++;
            end
            prev_mode = mr_mode;
            if (res_valid && res_ready) begin
                m_e.cyc  = cyc;
                m_e.id   = res_id;
                m_e.tag  = res_tag;
                m_e.data = res_data;
                pop_q.push_back(m_e);
            end
            popped_prev = res_valid && res_ready;
            acc_hist = {acc_hist[2:0], |m_acc};
        end
    end

    function automatic int sb_mismatch();
        int bad, n;
        bad = (acc_q.size() > pop_q.size()) ? acc_q.size() - pop_q.size() : pop_q.size() - acc_q.size();
        n = (acc_q.size() < pop_q.size()) ? acc_q.size() : pop_q.size();
        for (int i = 0; i < n; i++) begin
            if (pop_q[i].id !== acc_q[i].id || pop_q[i].tag !== acc_q[i].tag ||
                pop_q[i].data !== acc_q[i].data || pop_q[i].cyc - acc_q[i].cyc < 4) bad++;
        end
        return bad;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        req_d0   = rand46();
        req_d1   = rand46();
        req_tag0 = TAG_W'($urandom());
        req_tag1 = TAG_W'($urandom());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        req_mode = 2'b00;
        tick();
        tick();
        n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else n_pass++;
        n_checks++; if (res_id !== 1'b0) $display("FAIL reset_res_id: got %b want 0", res_id); else n_pass++;
        n_checks++; if (res_tag !== '0) $display("FAIL reset_res_tag: got %h want 0", res_tag); else n_pass++;
        n_checks++; if (res_data !== '0) $display("FAIL reset_res_data: got %h want 0", res_data); else n_pass++;
        n_checks++; if (mr_mode !== 1'b0) $display("FAIL reset_mr_mode: got %b want 0", mr_mode); else n_pass++;
        n_checks++; if (mr_d !== '0) $display("FAIL reset_mr_d: got %h want 0", mr_d); else n_pass++;
        n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %b want 00", req_ready); else n_pass++;
        req_valid = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        req_mode = 2'b00;
        req_d0 = '0;
        req_tag0 = 8'h11;
        req_valid = 2'b01;
        for (int i = 0; i < 10 && acc_q.size() == 0; i++) tick();
        req_valid = '0;
        repeat (8) tick();
        n_checks++;
        if (acc_q.size() != 1 || pop_q.size() != 1) begin
            $display("FAIL single_count: got acc=%0d res=%0d want 1/1", acc_q.size(), pop_q.size());
        end else begin
            n_pass++;
            n_checks++; if (pop_q[0].cyc - acc_q[0].cyc != 4) $display("FAIL single_latency: got %0d want 4", pop_q[0].cyc - acc_q[0].cyc); else n_pass++;
            n_checks++; if (pop_q[0].id !== 1'b0) $display("FAIL single_id: got %b want 0", pop_q[0].id); else n_pass++;
            n_checks++; if (pop_q[0].tag !== 8'h11) $display("FAIL single_tag: got %h want 11", pop_q[0].tag); else n_pass++;
            n_checks++; if (pop_q[0].data !== 24'd0) $display("FAIL single_data: got %h want 0", pop_q[0].data); else n_pass++;
        end
    endtask

    task automatic test_alternate();
        int alt_bad, lat_bad, thr_bad;
        do_reset();
        req_mode = 2'b00;
        req_valid = 2'b11;
        repeat (20) begin
            rand_ops();
            tick();
        end
        req_valid = '0;
        repeat (10) tick();
        alt_bad = 0; lat_bad = 0; thr_bad = 0;
        for (int i = 1; i < acc_q.size(); i++)
            if (acc_q[i].id == acc_q[i-1].id || acc_q[i].cyc != acc_q[i-1].cyc + 1) alt_bad++;
        for (int i = 0; i < pop_q.size() && i < acc_q.size(); i++)
            if (pop_q[i].cyc - acc_q[i].cyc != 4) lat_bad++;
        for (int i = 1; i < pop_q.size(); i++)
            if (pop_q[i].cyc != pop_q[i-1].cyc + 1) thr_bad++;
        n_checks++; if (acc_q.size() != 19) $display("FAIL alt_accepts: got %0d want 19", acc_q.size()); else n_pass++;
        n_checks++; if (acc_q.size() == 0 || acc_q[0].id !== 1'b0) $display("FAIL alt_first_id: got other want requester 0"); else n_pass++;
        n_checks++; if (alt_bad != 0) $display("FAIL alt_pattern: got %0d breaks want 0", alt_bad); else n_pass++;
        n_checks++; if (sb_mismatch() != 0) $display("FAIL alt_scoreboard: got %0d mismatches want 0", sb_mismatch()); else n_pass++;
        n_checks++; if (lat_bad != 0) $display("FAIL alt_latency: got %0d late results want 0", lat_bad); else n_pass++;
        n_checks++; if (thr_bad != 0) $display("FAIL alt_throughput: got %0d gaps want 0", thr_bad); else n_pass++;
    endtask

    task automatic test_mode_switch();
        int gap_bad, dil_hi, ch0;
        do_reset();
        ch0 = mode_changes;
        req_mode = 2'b10;
        req_valid = 2'b11;
        repeat (40) begin
            rand_ops();
            tick();
        end
        req_valid = '0;
        repeat (12) tick();
        gap_bad = 0; dil_hi = 0;
        for (int i = 1; i < acc_q.size(); i++)
            if (acc_q[i].id == acc_q[i-1].id || acc_q[i].cyc != acc_q[i-1].cyc + 4) gap_bad++;
        for (int i = 0; i < pop_q.size(); i++)
            if (pop_q[i].id == 1'b1 && pop_q[i].data[23:13] != 11'd0) dil_hi++;
        n_checks++; if (acc_q.size() != 10) $display("FAIL mix_accepts: got %0d want 10", acc_q.size()); else n_pass++;
        n_checks++; if (gap_bad != 0) $display("FAIL mix_gap: got %0d bad gaps want 0", gap_bad); else n_pass++;
        n_checks++; if (mode_bad != 0) $display("FAIL mix_mode_busy: got %0d toggles with work in flight want 0", mode_bad); else n_pass++;
        n_checks++; if (mode_changes - ch0 < 9) $display("FAIL mix_toggles: got %0d want >=9", mode_changes - ch0); else n_pass++;
        n_checks++; if (sb_mismatch() != 0) $display("FAIL mix_scoreboard: got %0d mismatches want 0", sb_mismatch()); else n_pass++;
        n_checks++; if (dil_hi == 0) $display("FAIL mix_dil_high_bits: got 0 results with [23:13] set want >0"); else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        res_ready = 1'b0;
        req_mode = 2'b00;
        req_valid = 2'b11;
        repeat (20) begin
            rand_ops();
            tick();
        end
        n_checks++; if (acc_q.size() != DEPTH) $display("FAIL bp_accepts: got %0d want %0d", acc_q.size(), DEPTH); else n_pass++;
        n_checks++; if (req_ready !== 2'b00) $display("FAIL bp_ready: got %b want 00", req_ready); else n_pass++;
        n_checks++; if (res_valid !== 1'b1) $display("FAIL bp_res_valid: got %b want 1", res_valid); else n_pass++;
        res_ready = 1'b1;
        repeat (30) begin
            rand_ops();
            tick();
        end
        req_valid = '0;
        repeat (12) tick();
        n_checks++; if (acc_q.size() <= DEPTH) $display("FAIL bp_resume: got %0d accepts want >%0d", acc_q.size(), DEPTH); else n_pass++;
        n_checks++; if (sb_mismatch() != 0) $display("FAIL bp_scoreboard: got %0d mismatches want 0", sb_mismatch()); else n_pass++;
        n_checks++; if (credit_bad != 0 || occ_bad != 0) $display("FAIL bp_credit: got credit=%0d occ=%0d want 0/0", credit_bad, occ_bad); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        res_ready = 1'b0;
        req_mode = 2'b11;
        req_valid = 2'b11;
        for (int i = 0; i < 30 && acc_q.size() < 5; i++) begin
            rand_ops();
            tick();
        end
        n_checks++; if (acc_q.size() != 5) $display("FAIL rmid_setup: got %0d accepts want 5", acc_q.size()); else n_pass++;
        n_checks++; if (res_valid !== 1'b1 || mr_mode !== 1'b1) $display("FAIL rmid_before: got valid=%b mode=%b want 1/1", res_valid, mr_mode); else n_pass++;
        rst = 1'b1;
        req_valid = '0;
        tick();
        n_checks++; if (res_valid !== 1'b0) $display("FAIL rmid_res_valid: got %b want 0", res_valid); else n_pass++;
        n_checks++; if (mr_mode !== 1'b0) $display("FAIL rmid_mr_mode: got %b want 0", mr_mode); else n_pass++;
        rst = 1'b0;
        res_ready = 1'b1;
        repeat (12) tick();
        n_checks++; if (pop_q.size() != 0 || occ_bad != 0) $display("FAIL rmid_stale: got %0d results occ=%0d want 0/0", pop_q.size(), occ_bad); else n_pass++;
    endtask

    task automatic test_kyber_upper();
        logic [45:0] ops [5];
        ops[0] = 46'h3FFF_FFFF_FFFF;
        ops[1] = 46'd3328;
        ops[2] = 46'd3329;
        ops[3] = 46'd8191;
        ops[4] = rand46();
        do_reset();
        req_mode = 2'b00;
        for (int k = 0; k < 5; k++) begin
            req_d0 = ops[k];
            req_tag0 = TAG_W'(k);
            req_valid = 2'b01;
            for (int i = 0; i < 10 && acc_q.size() <= k; i++) tick();
            req_valid = '0;
        end
        repeat (10) tick();
        n_checks++;
        if (pop_q.size() != 5) begin
            $display("FAIL kyb_count: got %0d want 5", pop_q.size());
        end else begin
            n_pass++;
            for (int k = 0; k < 5; k++) begin
                n_checks++;
                if (pop_q[k].data[23:13] !== 11'd0) $display("FAIL kyb_upper%0d: got %h want 0", k, pop_q[k].data[23:13]); else n_pass++;
                n_checks++;
                if (pop_q[k].data !== golden(1'b0, ops[k])) $display("FAIL kyb_data%0d: got %h want %h", k, pop_q[k].data, golden(1'b0, ops[k])); else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        req_mode = 2'(($urandom() % 2) ? 2'b11 : 2'b00);
        repeat (400) begin
            rand_ops();
            req_valid = 2'($urandom());
            if ($urandom_range(0, 15) == 0) req_mode[0] = ~req_mode[0];
            if ($urandom_range(0, 15) == 0) req_mode[1] = ~req_mode[1];
            res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        res_ready = 1'b1;
        repeat (20) tick();
        n_checks++; if (acc_q.size() < 50) $display("FAIL rnd_activity: got %0d accepts want >=50", acc_q.size()); else n_pass++;
        n_checks++; if (sb_mismatch() != 0) $display("FAIL rnd_scoreboard: got %0d mismatches want 0", sb_mismatch()); else n_pass++;
        n_checks++; if (credit_bad != 0) $display("FAIL rnd_credit: got %0d over-credit accepts want 0", credit_bad); else n_pass++;
        n_checks++; if (multi_bad != 0) $display("FAIL rnd_one_accept: got %0d double accepts want 0", multi_bad); else n_pass++;
        n_checks++; if (mode_bad != 0) $display("FAIL rnd_mode_busy: got %0d want 0", mode_bad); else n_pass++;
        n_checks++; if (occ_bad != 0) $display("FAIL rnd_occupancy: got %0d res_valid disagreements want 0", occ_bad); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_mode_switch();
        test_backpressure();
        test_reset_mid();
        test_kyber_upper();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
